shift_add_mac: RTL and testbench

- Sequential, parametrised shift-add multiply-accumulate engine for the IDCT datapath.
- Each accepted term is an unsigned sample times a sign-magnitude coefficient, formed one coefficient bit per cycle. The signed product is added into a full-width accumulator.
- After TERMS products it presents the dot product on a valid/ready output port.
- One instance computes one IDCT output point from a row or column of samples and coefficients.

---
 rtl/shift_add_mac.sv | 120 ++++++++++++
 tb/tb_shift_add_mac.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mac.sv
// Sequential shift-add multiply-accumulate engine for the IDCT datapath.
// Each term is an unsigned sample times a sign-magnitude coefficient, built one bit per cycle.
module shift_add_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 19,
    parameter int TERMS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    input  logic [COEF_W-1:0] coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam int PROD_W = DATA_W + COEF_W - 1;
    localparam int IDX_W  = (COEF_W > 2) ? $clog2(COEF_W - 1) : 1;
    localparam int CNT_W  = $clog2(TERMS + 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(COEF_W - 2);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(TERMS - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   data_q;
    logic [COEF_W-1:0]   coef_q;
    logic [PROD_W-1:0]   partial_q, partial_d;
    logic [IDX_W-1:0]    bitIdx_q;
    logic [CNT_W-1:0]    termCnt_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    result_q;
    logic                ovf_q;

    logic [PROD_W-1:0]   shiftedData;
    logic [ACC_W-1:0]    termExt;
    logic                accOvf;

    // Datapath: next partial product for the current magnitude bit, and the signed accumulate
    always_comb begin
        shiftedData = PROD_W'(data_q) << bitIdx_q;
        partial_d   = coef_q[bitIdx_q] ? partial_q + shiftedData : partial_q;
        termExt     = ACC_W'(partial_q);
        acc_d       = acc_q + termExt;
        accOvf      = (acc_q[ACC_W-1] == termExt[ACC_W-1]) && (acc_d[ACC_W-1] != acc_q[ACC_W-1]);
        if (coef_q[COEF_W-1]) begin
            acc_d  = acc_q - termExt;
            accOvf = (acc_q[ACC_W-1] != termExt[ACC_W-1]) && (acc_d[ACC_W-1] != acc_q[ACC_W-1]);
        end
    end

    // Control FSM; flush overrides every handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            coef_q    <= '0;
            partial_q <= '0;
            bitIdx_q  <= '0;
            termCnt_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else if (flush) begin
            state_q   <= IDLE;
            partial_q <= '0;
            termCnt_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q    <= data;
                        coef_q    <= coef;
                        partial_q <= '0;
                        bitIdx_q  <= '0;
                        state_q   <= MUL;
                    end
                end
                MUL: begin
                    partial_q <= partial_d;
                    bitIdx_q  <= bitIdx_q + 1'b1;
                    if (bitIdx_q == LAST_BIT) state_q <= ACC;
                end
                ACC: begin
                    acc_q     <= acc_d;
                    termCnt_q <= termCnt_q + 1'b1;
                    if (accOvf) ovf_q <= 1'b1;
                    if (termCnt_q == LAST_TERM) begin
                        result_q <= acc_d;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q     <= '0;
                        termCnt_q <= '0;
                        ovf_q     <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_shift_add_mac.sv
// Directed bench for shift_add_mac; a default instance and an ACC_W=16 instance share stimulus.
`timescale 1ns/1ps
module tb_shift_add_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [7:0]  coef = 8'h00;
    logic        in_ready, out_valid, overflow;
    logic [18:0] result;
    logic        in_ready16, out_valid16, overflow16;
    logic [15:0] result16;

    int checks = 0;
    int passes = 0;

    shift_add_mac dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .data(data), .coef(coef),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    shift_add_mac #(.ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready16), .data(data), .coef(coef),
        .out_valid(out_valid16), .out_ready(out_ready), .result(result16), .overflow(overflow16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Offer one term as soon as the engine is ready; data/coef are scrubbed after the accept edge
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        data = d;
        coef = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data = 8'h00;
        coef = 8'h00;
    endtask

    task automatic waitValid(output bit ok, output time tSeen);
        int n = 0;
        @(negedge clk);
        while (!(out_valid && out_valid16) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid && out_valid16;
        tSeen = $time;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, in_ready16, out_valid, out_valid16} !== 4'b1100)
            $display("[TB] FAIL reset_handshake: in_ready/out_valid=%b required 1100",
                     {in_ready, in_ready16, out_valid, out_valid16});
        else passes++;
        checks++;
        if (result !== 19'd0 || result16 !== 16'd0 || overflow !== 1'b0 || overflow16 !== 1'b0)
            $display("[TB] FAIL reset_result: result=%0d result16=%0d ovf=%b%b required 0",
                     result, result16, overflow, overflow16);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        time t0, tv;
        bit ok;
        longint edgeIdx;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'd255, 8'h7F);
            if (i == 0) begin
                t0 = $time - 1;
                checks++;
                if (in_ready !== 1'b0)
                    $display("[TB] FAIL busy_after_accept: in_ready=%b required 0", in_ready);
                else passes++;
            end
        end
        waitValid(ok, tv);
        checks++;
        if (!ok) $display("[TB] FAIL b2b_valid_timeout: out_valid=%b required 1", out_valid);
        else passes++;
        edgeIdx = longint'((tv - 5 - t0) / 10);
        checks++;
        if (edgeIdx != 71) $display("[TB] FAIL b2b_latency: edge=%0d required 71", edgeIdx);
        else passes++;
        checks++;
        if (result !== 19'd259080 || overflow !== 1'b0)
            $display("[TB] FAIL b2b_result: result=%0d ovf=%b required 259080 ovf=0", result, overflow);
        else passes++;
        checks++;
        if (result16 !== 16'hF408 || overflow16 !== 1'b1)
            $display("[TB] FAIL acc16_overflow: result=%h ovf=%b required f408 ovf=1", result16, overflow16);
        else passes++;
        handshake();
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL ready_after_handshake: in_ready=%b required 1", in_ready);
        else passes++;
    endtask

    task automatic test_overflow_recovery();
        time tv;
        bit ok;
        for (int i = 0; i < 8; i++) applyStimulus(8'd1, 8'h01);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'd8 || result16 !== 16'd8 || overflow !== 1'b0 || overflow16 !== 1'b0)
            $display("[TB] FAIL ovf_recovery: valid=%b result=%0d result16=%0d ovf=%b%b required 8 ovf=00",
                     ok, result, result16, overflow, overflow16);
        else passes++;
        handshake();
    endtask

    task automatic test_cancel();
        time tv;
        bit ok;
        for (int i = 0; i < 8; i++) applyStimulus(8'd10, (i % 2 == 0) ? 8'h05 : 8'h85);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'd0 || overflow !== 1'b0)
            $display("[TB] FAIL alternating_sign: valid=%b result=%0d ovf=%b required 0", ok, result, overflow);
        else passes++;
        handshake();
        for (int i = 0; i < 8; i++) applyStimulus(8'd200, 8'h80);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'd0 || overflow !== 1'b0)
            $display("[TB] FAIL negative_zero: valid=%b result=%0d ovf=%b required 0", ok, result, overflow);
        else passes++;
        handshake();
    endtask

    task automatic test_negative();
        time tv;
        bit ok;
        for (int i = 0; i < 8; i++) applyStimulus(8'd255, 8'hFF);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'h40BF8 || overflow !== 1'b0)
            $display("[TB] FAIL negative_sum: valid=%b result=%h ovf=%b required 40bf8 ovf=0", ok, result, overflow);
        else passes++;
        checks++;
        if (result16 !== 16'h0BF8 || overflow16 !== 1'b1)
            $display("[TB] FAIL negative_acc16: result=%h ovf=%b required 0bf8 ovf=1", result16, overflow16);
        else passes++;
        handshake();
    endtask

    task automatic test_backpressure();
        time tv;
        bit ok;
        bit stable = 1'b1;
        logic [18:0] held;
        for (int i = 0; i < 8; i++) applyStimulus(8'd1, 8'h10);
        waitValid(ok, tv);
        held = result;
        checks++;
        if (!ok || held !== 19'd128)
            $display("[TB] FAIL bp_result: valid=%b result=%0d required 128", ok, held);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            data = 8'd99;
            coef = 8'h7F;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) stable = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (!stable || out_valid !== 1'b1 || result !== held)
            $display("[TB] FAIL bp_hold: out_valid=%b result=%0d required held 128 with in_ready 0", out_valid, result);
        else passes++;
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passes++;
        for (int i = 0; i < 8; i++) applyStimulus(8'd2, 8'h03);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'd48)
            $display("[TB] FAIL bp_next_result: valid=%b result=%0d required 48", ok, result);
        else passes++;
        handshake();
    endtask

    task automatic test_flush();
        time tv;
        bit ok;
        for (int i = 0; i < 3; i++) applyStimulus(8'd255, 8'h7F);
        applyStimulus(8'd9, 8'h09);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        data = 8'd255;
        coef = 8'h7F;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL flush_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passes++;
        for (int i = 0; i < 8; i++) applyStimulus(8'd2, 8'h03);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'd48 || overflow !== 1'b0)
            $display("[TB] FAIL flush_next_result: valid=%b result=%0d ovf=%b required 48 ovf=0", ok, result, overflow);
        else passes++;
        handshake();
    endtask

    task automatic test_async_reset();
        time tv;
        bit ok;
        for (int i = 0; i < 3; i++) applyStimulus(8'd2, 8'h03);
        applyStimulus(8'd5, 8'h05);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 19'd0 || overflow !== 1'b0 || result16 !== 16'd0)
            $display("[TB] FAIL async_reset: in_ready=%b out_valid=%b result=%0d ovf=%b required 1/0/0/0",
                     in_ready, out_valid, result, overflow);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(8'd2, 8'h03);
        waitValid(ok, tv);
        checks++;
        if (!ok || result !== 19'd48 || overflow !== 1'b0)
            $display("[TB] FAIL reset_next_result: valid=%b result=%0d ovf=%b required 48 ovf=0", ok, result, overflow);
        else passes++;
        handshake();
    endtask

    // Scenarios run in sequence; each leaves the engine idle for the next
    initial begin
        test_reset();
        test_back_to_back();
        test_overflow_recovery();
        test_cancel();
        test_negative();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
